// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand selection, forwarding and
// load-use hazard detection for the pipelined MIPS core.
//
// Optional feature macro: ID_EX_FORWARD_EN
//   defined   : EX/MEM and MEM/WB results are forwarded into the ALU operands;
//               only a load-use dependency stalls ID.
//   undefined : no forwarding; any RAW against the instruction in EX or in
//               EX/MEM stalls ID until the producer reaches WB.
//
// There is no valid/ready handshake here: the stage advances every clock
// unless 'stall' freezes it; 'hazard' tells upstream to hold PC and IF/ID
// while this stage loads a bubble.

module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm32,
    input  logic [4:0]    id_shamt,
    input  logic [3:0]    id_alu_op,
    input  logic          id_src_a_shamt,
    input  logic          id_src_b_imm,
    input  logic          id_uses_rt,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          stall,
    input  logic          flush,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] ex_a,
    output logic [DW-1:0] ex_b,
    output logic [3:0]    ex_alu_op,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_rd,
    output logic          ex_valid,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          hazard
);

    // Bubbles carry the ADD opcode, which is the all-zero encoding.
    localparam logic [3:0] ALU_ADD = 4'd0;

    logic [DW-1:0] rs_data_q;
    logic [DW-1:0] rt_data_q;
    logic [DW-1:0] imm_q;
    logic [4:0]    shamt_q;
    logic          src_a_shamt_q;
    logic          src_b_imm_q;
    logic [RW-1:0] rs_q;
    logic [RW-1:0] rt_q;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    // Source-index match of the ID instruction against a given destination.
    logic id_hits_ex;
    logic id_hits_exmem;
    assign id_hits_ex    = (ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt));
    assign id_hits_exmem = (exmem_rd == id_rs) | (id_uses_rt & (exmem_rd == id_rt));

    // A load in EX cannot be forwarded in time; a load to $0 is harmless.
    logic load_use;
    assign load_use = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) & id_hits_ex;

`ifdef ID_EX_FORWARD_EN
    // Youngest producer wins: EX/MEM before MEM/WB before register file.
    function automatic logic [DW-1:0] pick_src(input logic [RW-1:0] idx,
                                               input logic [DW-1:0] rf_data);
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == idx))
            return exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == idx))
            return memwb_result;
        else
            return rf_data;
    endfunction

    assign fwd_rs = pick_src(rs_q, rs_data_q);
    assign fwd_rt = pick_src(rt_q, rt_data_q);
    assign hazard = load_use;
`else
    // Without forwarding, every in-flight producer ahead of WB blocks ID.
    logic ex_raw;
    logic exmem_raw;
    assign ex_raw    = id_valid & ex_valid & ex_reg_write & (ex_rd != '0) & id_hits_ex;
    assign exmem_raw = id_valid & exmem_reg_write & (exmem_rd != '0) & id_hits_exmem;

    assign fwd_rs = rs_data_q;
    assign fwd_rt = rt_data_q;
    assign hazard = load_use | ex_raw | exmem_raw;

    // Forwarding-only inputs and indices have no consumer in this build.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{exmem_result, memwb_reg_write, memwb_rd,
                                 memwb_result, rs_q, rt_q};
`endif

    // Operand selection feeding the ALU and the store path.
    assign ex_a          = src_a_shamt_q ? {{(DW-5){1'b0}}, shamt_q} : fwd_rs;
    assign ex_b          = src_b_imm_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;

    // Pipeline register: stall holds, flush/hazard load a bubble, else capture ID.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_alu_op     <= ALU_ADD;
            ex_rd         <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
            shamt_q       <= '0;
            src_a_shamt_q <= 1'b0;
            src_b_imm_q   <= 1'b0;
        end else if (stall) begin
            ex_valid <= ex_valid;
        end else if (flush || hazard) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_alu_op     <= ALU_ADD;
            ex_rd         <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
            shamt_q       <= '0;
            src_a_shamt_q <= 1'b0;
            src_b_imm_q   <= 1'b0;
        end else begin
            ex_valid      <= id_valid;
            ex_reg_write  <= id_valid & id_reg_write;
            ex_mem_read   <= id_valid & id_mem_read;
            ex_mem_write  <= id_valid & id_mem_write;
            ex_alu_op     <= id_alu_op;
            ex_rd         <= id_rd;
            rs_q          <= id_rs;
            rt_q          <= id_rt;
            rs_data_q     <= id_rs_data;
            rt_data_q     <= id_rt_data;
            imm_q         <= id_imm32;
            shamt_q       <= id_shamt;
            src_a_shamt_q <= id_src_a_shamt;
            src_b_imm_q   <= id_src_b_imm;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, forwarding priority, $0 handling,
// load-use bubbles, stall/flush interaction and the non-forwarding hazard path.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SLL = 4'd5;

    logic        clk;
    logic        rstn;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm32;
    logic [4:0]  id_shamt;
    logic [3:0]  id_alu_op;
    logic        id_src_a_shamt, id_src_b_imm, id_uses_rt;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        stall, flush;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_rd;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, hazard;

    int n_checks = 0;
    int n_pass   = 0;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm32(id_imm32),
        .id_shamt(id_shamt), .id_alu_op(id_alu_op),
        .id_src_a_shamt(id_src_a_shamt), .id_src_b_imm(id_src_b_imm),
        .id_uses_rt(id_uses_rt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .stall(stall), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
        .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_a(ex_a), .ex_b(ex_b), .ex_alu_op(ex_alu_op),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .hazard(hazard)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Advance one edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm32 = 0; id_shamt = 0;
        id_alu_op = OP_ADD; id_src_a_shamt = 0; id_src_b_imm = 0; id_uses_rt = 0;
        id_rs = 0; id_rt = 0; id_rd = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    endtask

    task automatic clear_fwd();
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [31:0] rs_data, input logic [31:0] rt_data,
                            input logic [3:0] op, input logic rw, input logic mr,
                            input logic mw, input logic uses_rt);
        clear_id();
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rs_data; id_rt_data = rt_data; id_alu_op = op;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_uses_rt = uses_rt;
    endtask

    initial begin
        // Reset, released mid-cycle with a valid instruction in ID
        rstn = 0; stall = 0; flush = 0;
        clear_fwd();
        drive_id(5'd1, 5'd0, 5'd7, 32'hA, 32'h0, OP_ADD, 1, 0, 0, 0);
        #12;
        rstn = 1;
        #1;
        check("rst_valid", {31'b0, ex_valid}, 0);
        check("rst_a", ex_a, 0);
        check("rst_rd", {27'b0, ex_rd}, 0);
        check("rst_rw", {31'b0, ex_reg_write}, 0);
        check("rst_hazard", {31'b0, hazard}, 0);
        tick();
        check("first_valid", {31'b0, ex_valid}, 1);
        check("first_a", ex_a, 32'hA);
        check("first_rd", {27'b0, ex_rd}, 7);
        check("first_rw", {31'b0, ex_reg_write}, 1);

        // Forwarding priority (store with rs=3, rt=4, imm B)
        drive_id(5'd3, 5'd4, 5'd8, 32'h5, 32'h33, OP_ADD, 0, 0, 1, 1);
        id_src_b_imm = 1; id_imm32 = 32'h100;
        tick();
        clear_id();
        exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'h11;
        #1;
        check("fwd_exmem_a", ex_a, FWD ? 32'h11 : 32'h5);
        check("fwd_imm_b", ex_b, 32'h100);
        check("fwd_mem_write", {31'b0, ex_mem_write}, 1);
        memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'h22;
        #1;
        check("fwd_prio_a", ex_a, FWD ? 32'h11 : 32'h5);
        exmem_rd = 4;
        #1;
        check("fwd_memwb_a", ex_a, FWD ? 32'h22 : 32'h5);
        check("fwd_store_data", ex_store_data, FWD ? 32'h11 : 32'h33);
        clear_fwd();

        // No forwarding from $0
        drive_id(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, OP_ADD, 0, 0, 0, 0);
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'h99;
        memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'h77;
        tick();
        check("zero_a", ex_a, 0);
        check("zero_valid", {31'b0, ex_valid}, 1);
        clear_fwd();

        // Load-use: LW $5 then a reader of $5
        drive_id(5'd1, 5'd0, 5'd5, 32'h1000, 32'h0, OP_ADD, 1, 1, 0, 0);
        tick();
        check("lw_mem_read", {31'b0, ex_mem_read}, 1);
        drive_id(5'd5, 5'd0, 5'd6, 32'h55, 32'h0, OP_ADD, 1, 0, 0, 0);
        #1;
        check("lu_hazard", {31'b0, hazard}, 1);
        tick();
        check("lu_bubble_valid", {31'b0, ex_valid}, 0);
        check("lu_bubble_rw", {31'b0, ex_reg_write}, 0);
        check("lu_bubble_mr", {31'b0, ex_mem_read}, 0);
        check("lu_bubble_rd", {27'b0, ex_rd}, 0);
        check("lu_hazard_clear", {31'b0, hazard}, 0);
        tick();
        check("lu_cap_valid", {31'b0, ex_valid}, 1);
        check("lu_cap_rd", {27'b0, ex_rd}, 6);
        check("lu_cap_a", ex_a, 32'h55);

        // Stall with flush, then flush alone, then SLL shamt=4
        drive_id(5'd0, 5'd2, 5'd9, 32'h0, 32'h66, OP_SLL, 1, 0, 0, 1);
        id_shamt = 5'd4; id_src_a_shamt = 1;
        stall = 1; flush = 1;
        tick();
        check("stall1_rd", {27'b0, ex_rd}, 6);
        check("stall1_valid", {31'b0, ex_valid}, 1);
        tick();
        check("stall2_rd", {27'b0, ex_rd}, 6);
        check("stall2_a", ex_a, 32'h55);
        stall = 0;
        tick();
        check("flush_valid", {31'b0, ex_valid}, 0);
        check("flush_rd", {27'b0, ex_rd}, 0);
        check("flush_rw", {31'b0, ex_reg_write}, 0);
        flush = 0;
        tick();
        check("sll_a", ex_a, 32'h4);
        check("sll_b", ex_b, 32'h66);
        check("sll_op", {28'b0, ex_alu_op}, {28'b0, OP_SLL});
        check("sll_rd", {27'b0, ex_rd}, 9);
        check("sll_store", ex_store_data, 32'h66);
        clear_id();
        exmem_reg_write = 1; exmem_rd = 2; exmem_result = 32'h77;
        #1;
        check("sll_fwd_b", ex_b, FWD ? 32'h77 : 32'h66);
        check("sll_fwd_a", ex_a, 32'h4);
        clear_fwd();

        // RAW on a plain ALU producer: ADD $2 then a reader of $2
        drive_id(5'd1, 5'd0, 5'd2, 32'h1, 32'h0, OP_ADD, 1, 0, 0, 0);
        tick();
        drive_id(5'd2, 5'd0, 5'd10, 32'hAB, 32'h0, OP_ADD, 1, 0, 0, 0);
        #1;
        check("raw_ex_hazard", {31'b0, hazard}, FWD ? 0 : 1);
        tick();
        check("raw_ex_valid", {31'b0, ex_valid}, FWD ? 1 : 0);
        exmem_reg_write = 1; exmem_rd = 2; exmem_result = 32'h3;
        #1;
        check("raw_mem_hazard", {31'b0, hazard}, FWD ? 0 : 1);
        tick();
        clear_fwd();
        memwb_reg_write = 1; memwb_rd = 2; memwb_result = 32'h3;
        #1;
        check("raw_wb_hazard", {31'b0, hazard}, 0);
        tick();
        check("raw_cap_valid", {31'b0, ex_valid}, 1);
        check("raw_cap_rd", {27'b0, ex_rd}, 10);
        check("raw_cap_a", ex_a, FWD ? 32'h3 : 32'hAB);
        clear_fwd();
        clear_id();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
